// File: rtl/exec_pkg.sv
// Shared definitions for the clocked execute stage: ALU opcodes, channel
// field layout helpers, handshake FSM states and the result-entry tail.
package exec_pkg;

  // ALU control codes; the legacy 3-bit codes are these with MSB clear
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;

  typedef enum logic [1:0] {
    IN_IDLE = 2'd0,
    IN_REQ  = 2'd1,
    IN_RTZ  = 2'd2
  } inState_e;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_REQ  = 2'd1,
    OUT_RTZ  = 2'd2
  } outState_e;

  // Low five bits of every result entry (and of the e2m bus)
  typedef struct packed {
    logic regWrite;
    logic memtoReg;
    logic memWrite;
    logic zero;
    logic ovf;
  } resFlags_t;

  // d2e = {SrcA,SrcB,Rs,Rt,Rd,SignImm,RegWrite,MemtoReg,MemWrite,ALUCtrl,ALUSrc,RegDst}
  function automatic int d2eWidth(int xlen, int rw, int opw);
    return 3*xlen + 3*rw + opw + 5;
  endfunction

  function automatic int d2eCtrlOff(int opw);     return 2;                        endfunction
  function automatic int d2eMemWriteOff(int opw); return opw + 2;                  endfunction
  function automatic int d2eMemtoRegOff(int opw); return opw + 3;                  endfunction
  function automatic int d2eRegWriteOff(int opw); return opw + 4;                  endfunction
  function automatic int d2eImmOff(int opw);      return opw + 5;                  endfunction
  function automatic int d2eRdOff(int xlen, int opw);
    return opw + 5 + xlen;
  endfunction
  function automatic int d2eRtOff(int xlen, int rw, int opw);
    return opw + 5 + xlen + rw;
  endfunction
  function automatic int d2eRsOff(int xlen, int rw, int opw);
    return opw + 5 + xlen + 2*rw;
  endfunction
  function automatic int d2eSrcBOff(int xlen, int rw, int opw);
    return opw + 5 + xlen + 3*rw;
  endfunction
  function automatic int d2eSrcAOff(int xlen, int rw, int opw);
    return opw + 5 + 2*xlen + 3*rw;
  endfunction

  // e2m = {ALUOut,WriteData,WriteReg,RegWrite,MemtoReg,MemWrite,Zero,Ovf}
  function automatic int e2mWidth(int xlen, int rw);
    return 2*xlen + rw + 5;
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational extended ALU: logic ops, add/sub with signed overflow,
// signed/unsigned compare, shifts and load-upper-immediate.
module exec_alu
  import exec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [OPW-1:0]  op_i,
  output logic [XLEN-1:0] aluOut_o,
  output logic            zero_o,
  output logic            ovf_o
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;

  assign shamt  = b_i[SW-1:0];
  assign sum    = a_i + b_i;
  assign diff   = a_i - b_i;
  assign zero_o = (aluOut_o == '0);

  // Select the result by opcode; overflow only means something for ADD/SUB
  always_comb begin
    aluOut_o = '0;
    ovf_o    = 1'b0;
    case (op_i)
      OPW'(ALU_AND):  aluOut_o = a_i & b_i;
      OPW'(ALU_OR):   aluOut_o = a_i | b_i;
      OPW'(ALU_ADD): begin
        aluOut_o = sum;
        ovf_o    = (a_i[XLEN-1] == b_i[XLEN-1]) && (sum[XLEN-1] != a_i[XLEN-1]);
      end
      OPW'(ALU_XOR):  aluOut_o = a_i ^ b_i;
      OPW'(ALU_NOR):  aluOut_o = ~(a_i | b_i);
      OPW'(ALU_SLL):  aluOut_o = a_i << shamt;
      OPW'(ALU_SUB): begin
        aluOut_o = diff;
        ovf_o    = (a_i[XLEN-1] != b_i[XLEN-1]) && (diff[XLEN-1] != a_i[XLEN-1]);
      end
      OPW'(ALU_SLT):  aluOut_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OPW'(ALU_SLTU): aluOut_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      OPW'(ALU_SRL):  aluOut_o = a_i >> shamt;
      OPW'(ALU_SRA):  aluOut_o = $unsigned($signed(a_i) >>> shamt);
      OPW'(ALU_LUI):  aluOut_o = b_i << (XLEN/2);
      default:        aluOut_o = '0;
    endcase
  end

endmodule

// File: rtl/exec_stage_buf.sv
// Clocked execute stage: pulls operands over four-phase d2e, runs the ALU,
// queues results in a DEPTH-entry FIFO and pushes them over four-phase e2m.
module exec_stage_buf
  import exec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RW    = 5,
  parameter int DEPTH = 4,
  parameter int OPW   = 4
) (
  input  logic                               clk,
  input  logic                               Z_R,
  output logic                               d2e_R,
  input  logic                               d2e_A,
  input  logic [d2eWidth(XLEN, RW, OPW)-1:0] d2e,
  output logic                               e2m_R,
  input  logic                               e2m_A,
  output logic [e2mWidth(XLEN, RW)-1:0]      e2m,
  output logic [$clog2(DEPTH+1)-1:0]         count
);

  localparam int E2MW = e2mWidth(XLEN, RW);
  localparam int CW   = $clog2(DEPTH+1);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MEMN = 1 << PW;

  // Operand fields
  logic [XLEN-1:0] srcA, srcB, signImm, bPrime, aluOut;
  logic [RW-1:0]   rt, rd, writeReg;
  logic [OPW-1:0]  aluCtrl;
  logic            aluSrc, regDst, zero, ovf;
  logic            unusedRs;
  resFlags_t       flags;
  logic [E2MW-1:0] entry;

  assign srcA     = d2e[d2eSrcAOff(XLEN, RW, OPW) +: XLEN];
  assign srcB     = d2e[d2eSrcBOff(XLEN, RW, OPW) +: XLEN];
  assign rt       = d2e[d2eRtOff(XLEN, RW, OPW) +: RW];
  assign rd       = d2e[d2eRdOff(XLEN, OPW) +: RW];
  assign signImm  = d2e[d2eImmOff(OPW) +: XLEN];
  assign aluCtrl  = d2e[d2eCtrlOff(OPW) +: OPW];
  assign aluSrc   = d2e[1];
  assign regDst   = d2e[0];
  assign unusedRs = ^d2e[d2eRsOff(XLEN, RW, OPW) +: RW];

  assign bPrime   = aluSrc ? signImm : srcB;
  assign writeReg = regDst ? rd : rt;

  exec_alu #(.XLEN(XLEN), .OPW(OPW)) uAlu (
    .a_i      (srcA),
    .b_i      (bPrime),
    .op_i     (aluCtrl),
    .aluOut_o (aluOut),
    .zero_o   (zero),
    .ovf_o    (ovf)
  );

  assign flags = '{regWrite: d2e[d2eRegWriteOff(OPW)],
                   memtoReg: d2e[d2eMemtoRegOff(OPW)],
                   memWrite: d2e[d2eMemWriteOff(OPW)],
                   zero:     zero,
                   ovf:      ovf};
  assign entry = {aluOut, srcB, writeReg, flags};

  // Buffer state
  inState_e        inState_q;
  outState_e       outState_q;
  logic            d2eR_q, e2mR_q;
  logic [E2MW-1:0] e2m_q;
  logic [E2MW-1:0] mem_q [MEMN];
  logic [PW-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop, haveRoom;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign push     = (inState_q == IN_REQ) && d2e_A;
  assign pop      = (outState_q == OUT_REQ) && e2m_A;
  // A pop in the same cycle frees a slot, so it counts as room
  assign haveRoom = (count_q < CW'(DEPTH)) || pop;

  // Next occupancy and pointers; push and pop together leave count alone
  always_comb begin
    count_d = count_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (!push && pop) count_d = count_q - CW'(1);
    if (push) wrPtr_d = bump(wrPtr_q);
    if (pop)  rdPtr_d = bump(rdPtr_q);
  end

  // Occupancy and pointer registers; reset flushes the buffer
  always_ff @(posedge clk) begin
    if (Z_R) begin
      count_q <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      count_q <= count_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Capture the computed result into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (!Z_R && push) mem_q[wrPtr_q] <= entry;
  end

  // Input side: request only with room and the producer back at zero
  always_ff @(posedge clk) begin
    if (Z_R) begin
      inState_q <= IN_IDLE;
      d2eR_q    <= 1'b0;
    end else begin
      case (inState_q)
        IN_IDLE: if (haveRoom && !d2e_A) begin
          inState_q <= IN_REQ;
          d2eR_q    <= 1'b1;
        end
        IN_REQ: if (d2e_A) begin
          inState_q <= IN_RTZ;
          d2eR_q    <= 1'b0;
        end
        IN_RTZ: if (!d2e_A) inState_q <= IN_IDLE;
        default: begin
          inState_q <= IN_IDLE;
          d2eR_q    <= 1'b0;
        end
      endcase
    end
  end

  // Output side: load the head entry when offering, pop on acknowledge
  always_ff @(posedge clk) begin
    if (Z_R) begin
      outState_q <= OUT_IDLE;
      e2mR_q     <= 1'b0;
      e2m_q      <= '0;
    end else begin
      case (outState_q)
        OUT_IDLE: if ((count_q != '0) && !e2m_A) begin
          outState_q <= OUT_REQ;
          e2mR_q     <= 1'b1;
          e2m_q      <= mem_q[rdPtr_q];
        end
        OUT_REQ: if (e2m_A) begin
          outState_q <= OUT_RTZ;
          e2mR_q     <= 1'b0;
        end
        OUT_RTZ: if (!e2m_A) outState_q <= OUT_IDLE;
        default: begin
          outState_q <= OUT_IDLE;
          e2mR_q     <= 1'b0;
        end
      endcase
    end
  end

  assign d2e_R = d2eR_q;
  assign e2m_R = e2mR_q;
  assign e2m   = e2m_q;
  assign count = count_q;

endmodule

// File: tb/tb_exec_stage_buf.sv
// Bench for exec_stage_buf: a 32-bit DEPTH=2 instance driven with directed
// and random operations, plus a 16-bit DEPTH=1 instance.
module tb_exec_stage_buf;

  localparam int DW  = 120;
  localparam int EW  = 74;
  localparam int DWS = 72;
  localparam int EWS = 42;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           zR;
  logic           d2eR, d2eA, e2mR, e2mA;
  logic [DW-1:0]  d2eBus;
  logic [EW-1:0]  e2mBus;
  logic [1:0]     cnt;
  logic           d2eRS, d2eAS, e2mRS, e2mAS;
  logic [DWS-1:0] d2eBusS;
  logic [EWS-1:0] e2mBusS;
  logic [0:0]     cntS;

  exec_stage_buf #(.XLEN(32), .RW(5), .DEPTH(2), .OPW(4)) dut (
    .clk(clk), .Z_R(zR), .d2e_R(d2eR), .d2e_A(d2eA), .d2e(d2eBus),
    .e2m_R(e2mR), .e2m_A(e2mA), .e2m(e2mBus), .count(cnt)
  );

  exec_stage_buf #(.XLEN(16), .RW(5), .DEPTH(1), .OPW(4)) dut16 (
    .clk(clk), .Z_R(zR), .d2e_R(d2eRS), .d2e_A(d2eAS), .d2e(d2eBusS),
    .e2m_R(e2mRS), .e2m_A(e2mAS), .e2m(e2mBusS), .count(cntS)
  );

  int testsRun = 0;
  int testsFailed = 0;
  logic [127:0] expQ[$];

  task automatic compare(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference ALU in plain integer arithmetic over an xlen-bit word
  function automatic logic [63:0] aluRef(input int xlen, input int op,
                                         input logic [63:0] a, input logic [63:0] b,
                                         output bit ovf);
    logic [63:0] mask, ua, ub, r;
    longint sa, sb, s, lim;
    int sh;
    mask = (64'd1 << xlen) - 64'd1;
    ua = a & mask;
    ub = b & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (ua[xlen-1]) sa = sa - longint'(64'd1 << xlen);
    if (ub[xlen-1]) sb = sb - longint'(64'd1 << xlen);
    lim = longint'(64'd1 << (xlen-1));
    sh  = int'(ub % 64'(xlen));
    ovf = 1'b0;
    r   = 64'd0;
    case (op)
      0:  r = ua & ub;
      1:  r = ua | ub;
      2:  begin s = sa + sb; r = 64'(s) & mask; ovf = (s >= lim) || (s < -lim); end
      3:  r = ua ^ ub;
      4:  r = ~(ua | ub) & mask;
      5:  r = (ua << sh) & mask;
      6:  begin s = sa - sb; r = 64'(s) & mask; ovf = (s >= lim) || (s < -lim); end
      7:  r = (sa < sb) ? 64'd1 : 64'd0;
      8:  r = (ua < ub) ? 64'd1 : 64'd0;
      9:  r = ua >> sh;
      10: r = 64'(sa >>> sh) & mask;
      11: r = (ub << (xlen/2)) & mask;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] packD2e(input int xlen, input logic [63:0] a, b, imm,
                                           input logic [4:0] rs, rt, rd,
                                           input bit rw, m2r, mw, input logic [3:0] op,
                                           input bit asrc, rdst);
    logic [127:0] v;
    v = 128'(a);
    v = (v << xlen) | 128'(b);
    v = (v << 5) | 128'(rs);
    v = (v << 5) | 128'(rt);
    v = (v << 5) | 128'(rd);
    v = (v << xlen) | 128'(imm);
    v = (v << 3) | 128'({rw, m2r, mw});
    v = (v << 4) | 128'(op);
    v = (v << 2) | 128'({asrc, rdst});
    return v;
  endfunction

  // Expected e2m word from the datapath rules
  function automatic logic [127:0] expectFor(input int xlen, input logic [3:0] op,
                                             input logic [63:0] a, b, imm,
                                             input logic [4:0] rt, rd,
                                             input bit rw, m2r, mw, asrc, rdst);
    logic [127:0] v;
    logic [63:0] r;
    bit o;
    r = aluRef(xlen, int'(op), a, asrc ? imm : b, o);
    v = 128'(r);
    v = (v << xlen) | 128'(b);
    v = (v << 5) | 128'(rdst ? rd : rt);
    v = (v << 5) | 128'({rw, m2r, mw, (r == 64'd0), o});
    return v;
  endfunction

  // Offer one operation to the 32-bit instance over d2e
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, b, imm,
                               input logic [4:0] rt, rd, input bit asrc, rdst);
    logic [4:0] rs;
    bit rw, m2r, mw;
    int n;
    rs = 5'($urandom); rw = 1'($urandom); m2r = 1'($urandom); mw = 1'($urandom);
    n = 0;
    while (d2eR !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    compare("d2e_R request", d2eR, 1'b1);
    if (d2eR === 1'b1) begin
      d2eBus = DW'(packD2e(32, a, b, imm, rs, rt, rd, rw, m2r, mw, op, asrc, rdst));
      d2eA = 1'b1;
      expQ.push_back(expectFor(32, op, a, b, imm, rt, rd, rw, m2r, mw, asrc, rdst));
      n = 0;
      @(negedge clk);
      while (d2eR !== 1'b0 && n < 10) begin @(negedge clk); n++; end
      d2eA = 1'b0;
    end
  endtask

  // Accept one result from the 32-bit instance and compare with the model
  task automatic checkOutput(input string tag, input bit chk,
                             input logic [31:0] aluExp, input logic [1:0] zo);
    int n;
    logic [127:0] expv;
    n = 0;
    while (e2mR !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    compare({tag, " e2m_R"}, e2mR, 1'b1);
    if (e2mR === 1'b1) begin
      if (expQ.size() == 0) begin
        compare({tag, " spurious e2m_R"}, e2mR, 1'b0);
      end else begin
        expv = expQ.pop_front();
        compare({tag, " e2m"}, e2mBus, expv);
      end
      if (chk) begin
        compare({tag, " ALUOut"}, e2mBus[73:42], aluExp);
        compare({tag, " Zero/Ovf"}, e2mBus[1:0], zo);
      end
      e2mA = 1'b1;
      n = 0;
      @(negedge clk);
      while (e2mR !== 1'b0 && n < 10) begin @(negedge clk); n++; end
      compare({tag, " e2m_R drop"}, e2mR, 1'b0);
      e2mA = 1'b0;
    end
  endtask

  task automatic directed(input string tag, input logic [3:0] op, input logic [31:0] a, b, imm,
                          input bit asrc, rdst, input logic [4:0] rt, rd,
                          input logic [31:0] aluExp, input logic [1:0] zo);
    applyStimulus(op, a, b, imm, rt, rd, asrc, rdst);
    checkOutput(tag, 1'b1, aluExp, zo);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b, imm;
    logic [15:0] a16, b16, imm16;
    logic [4:0]  rtS, rdS, rsS;
    bit          asrc, rdst, rwS, m2rS, mwS;
    logic [127:0] expS;
    int n;

    zR = 1'b1; d2eA = 1'b0; e2mA = 1'b0; d2eBus = '0;
    d2eAS = 1'b0; e2mAS = 1'b0; d2eBusS = '0;
    repeat (2) @(negedge clk);
    compare("reset d2e_R", d2eR, 1'b0);
    compare("reset e2m_R", e2mR, 1'b0);
    compare("reset e2m", e2mBus, '0);
    compare("reset count", cnt, 2'd0);
    compare("reset count16", cntS, 1'b0);
    zR = 1'b0;

    // Legacy and extended operations with fixed operands
    directed("add", 4'd2, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0, 0, 1, 5'h03, 5'h0A, 32'hFFFFFFFF, 2'b00);
    directed("addi", 4'd2, 32'hA5A5A5A5, 32'h12345678, 32'h25252525, 1, 0, 5'h05, 5'h09, 32'hCACACACA, 2'b00);
    directed("sub", 4'd6, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0, 0, 1, 5'h01, 5'h02, 32'h4B4B4B4B, 2'b01);
    directed("and", 4'd0, 32'hA5A5A5A5, 32'h5AFF5AFF, 32'h0, 0, 0, 5'h07, 5'h08, 32'h00A500A5, 2'b00);
    directed("or", 4'd1, 32'hA5A5A5A5, 32'h5A005A00, 32'h0, 0, 1, 5'h07, 5'h1F, 32'hFFA5FFA5, 2'b00);
    directed("slt", 4'd7, 32'h05A5A5A5, 32'h5A005A00, 32'h0, 0, 0, 5'h04, 5'h06, 32'h00000001, 2'b00);
    directed("slt eq", 4'd7, 32'h12345678, 32'h12345678, 32'h0, 0, 0, 5'h04, 5'h06, 32'h0, 2'b10);
    directed("sra", 4'd10, 32'h80000000, 32'h00000004, 32'h0, 0, 0, 5'h02, 5'h03, 32'hF8000000, 2'b00);
    directed("srl", 4'd9, 32'h80000000, 32'h00000004, 32'h0, 0, 0, 5'h02, 5'h03, 32'h08000000, 2'b00);
    directed("sltu", 4'd8, 32'hFFFFFFFF, 32'h00000001, 32'h0, 0, 0, 5'h02, 5'h03, 32'h0, 2'b10);
    directed("nor", 4'd4, 32'h0, 32'h0, 32'h0, 0, 1, 5'h02, 5'h03, 32'hFFFFFFFF, 2'b00);
    directed("lui", 4'd11, 32'h0, 32'hDEADBEEF, 32'h00001234, 1, 1, 5'h02, 5'h03, 32'h12340000, 2'b00);
    directed("op 1111", 4'd15, 32'hFFFF0000, 32'h0000FFFF, 32'h0, 0, 1, 5'h02, 5'h03, 32'h0, 2'b10);

    // Backpressure: two results fill the buffer, the third waits for a pop
    applyStimulus(4'd2, 32'h1, 32'h2, 32'h0, 5'h01, 5'h11, 0, 1);
    applyStimulus(4'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 5'h02, 5'h12, 0, 1);
    compare("bp count full", cnt, 2'd2);
    repeat (5) begin
      @(negedge clk);
      compare("bp d2e_R held", d2eR, 1'b0);
    end
    checkOutput("bp first", 1'b1, 32'h00000003, 2'b00);
    applyStimulus(4'd6, 32'h10, 32'h1, 32'h0, 5'h03, 5'h13, 0, 1);
    compare("bp count refill", cnt, 2'd2);
    checkOutput("bp second", 1'b1, 32'hFF00FF00, 2'b00);
    checkOutput("bp third", 1'b1, 32'h0000000F, 2'b00);

    // Random operations, draining whenever the buffer is full
    for (int i = 0; i < 24; i++) begin
      if (expQ.size() >= 2) checkOutput("rand drain", 1'b0, '0, '0);
      op = 4'($urandom); a = $urandom; imm = $urandom;
      b = ($urandom_range(3, 0) == 0) ? a : $urandom;
      asrc = 1'($urandom); rdst = 1'($urandom);
      applyStimulus(op, a, b, imm, 5'($urandom), 5'($urandom), asrc, rdst);
      if ($urandom_range(1, 0) == 1) checkOutput("rand", 1'b0, '0, '0);
    end
    for (int j = 0; j < 2 && expQ.size() > 0; j++) checkOutput("rand tail", 1'b0, '0, '0);

    // Reset in the middle of both handshakes
    applyStimulus(4'd2, 32'h5, 32'h5, 32'h0, 5'h01, 5'h02, 0, 0);
    repeat (3) @(negedge clk);
    compare("pre-reset d2e_R", d2eR, 1'b1);
    compare("pre-reset e2m_R", e2mR, 1'b1);
    compare("pre-reset count", cnt, 2'd1);
    zR = 1'b1; d2eA = 1'b1; d2eBus = DW'({$urandom, $urandom, $urandom, $urandom});
    @(negedge clk);
    compare("mid-reset d2e_R", d2eR, 1'b0);
    compare("mid-reset e2m_R", e2mR, 1'b0);
    compare("mid-reset count", cnt, 2'd0);
    compare("mid-reset e2m", e2mBus, '0);
    zR = 1'b0;
    expQ.delete();
    repeat (3) begin
      @(negedge clk);
      compare("post-reset d2e_R waits", d2eR, 1'b0);
      compare("post-reset e2m_R empty", e2mR, 1'b0);
    end
    d2eA = 1'b0;
    directed("post-reset", 4'd1, 32'h0F0F0000, 32'h0000F0F0, 32'h0, 0, 1, 5'h01, 5'h1A, 32'h0F0FF0F0, 2'b00);

    // 16-bit, single-entry instance: full and empty alternate
    for (int k = 0; k < 6; k++) begin
      op = (k == 0) ? 4'd2 : 4'($urandom);
      a16 = (k == 0) ? 16'h7FFF : 16'($urandom);
      b16 = (k == 0) ? 16'h0001 : 16'($urandom);
      imm16 = 16'($urandom);
      asrc = (k == 0) ? 1'b0 : 1'($urandom);
      rdst = 1'($urandom);
      rsS = 5'($urandom); rtS = 5'($urandom); rdS = 5'($urandom);
      rwS = 1'($urandom); m2rS = 1'($urandom); mwS = 1'($urandom);
      n = 0;
      while (d2eRS !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      compare("x16 d2e_R request", d2eRS, 1'b1);
      d2eBusS = DWS'(packD2e(16, 64'(a16), 64'(b16), 64'(imm16), rsS, rtS, rdS, rwS, m2rS, mwS, op, asrc, rdst));
      expS = expectFor(16, op, 64'(a16), 64'(b16), 64'(imm16), rtS, rdS, rwS, m2rS, mwS, asrc, rdst);
      d2eAS = 1'b1;
      n = 0;
      @(negedge clk);
      while (d2eRS !== 1'b0 && n < 10) begin @(negedge clk); n++; end
      d2eAS = 1'b0;
      repeat (3) @(negedge clk);
      compare("x16 count full", cntS, 1'b1);
      compare("x16 d2e_R held", d2eRS, 1'b0);
      n = 0;
      while (e2mRS !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      compare("x16 e2m_R", e2mRS, 1'b1);
      compare("x16 e2m", e2mBusS, expS);
      if (k == 0) begin
        compare("x16 add ALUOut", e2mBusS[41:26], 16'h8000);
        compare("x16 add Ovf", e2mBusS[0], 1'b1);
      end
      e2mAS = 1'b1;
      n = 0;
      @(negedge clk);
      while (e2mRS !== 1'b0 && n < 10) begin @(negedge clk); n++; end
      e2mAS = 1'b0;
      compare("x16 count empty", cntS, 1'b0);
    end
    repeat (4) @(negedge clk);
    compare("x16 no duplicate", e2mRS, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
